// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the oldest pipeline exception (or mret), then
// runs FLUSH -> COMMIT -> REDIRECT, writing mepc/mcause/mtval and steering fetch.
module trap_ctrl #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   exceptF,
  input  logic [N-1:0] pcF,
  input  logic [2:0]   exceptD,
  input  logic         mretD,
  input  logic [N-1:0] pcD,
  input  logic [5:0]   exceptM,
  input  logic [N-1:0] pcM,
  input  logic [N-1:0] addrM,
  input  logic [N-1:0] mtvec,
  input  logic         fetchReady,
  output logic         stall,
  output logic         flush,
  output logic         redirectValid,
  output logic [N-1:0] pcRedirect,
  output logic [N-1:0] mepc,
  output logic [N-1:0] mtval,
  output logic [N-1:0] mcause,
  output logic         inTrap
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;

  state_t         state;
  logic           kind_mret;
  logic [3:0]     cause_q;
  logic [N-1:0]   epc_q;
  logic [N-1:0]   tval_q;

  logic           any_exc;
  logic [3:0]     cause_d;
  logic [N-1:0]   epc_d;
  logic [N-1:0]   tval_d;

  // Oldest stage wins (M > D > F); within a stage the fixed cause priority applies.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_exc = (|exceptM) || (|exceptD) || (|exceptF);
    cause_d = 4'd0;
    epc_d   = '0;
    tval_d  = '0;
    if (|exceptM) begin
      epc_d  = pcM;
      tval_d = addrM;
      if      (exceptM[0]) cause_d = 4'd4;
      else if (exceptM[2]) cause_d = 4'd5;
      else if (exceptM[4]) cause_d = 4'd13;
      else if (exceptM[1]) cause_d = 4'd6;
      else if (exceptM[3]) cause_d = 4'd7;
      else                 cause_d = 4'd15;
    end else if (|exceptD) begin
      epc_d = pcD;
      if      (exceptD[0]) cause_d = 4'd2;
      else if (exceptD[1]) cause_d = 4'd3;
      else                 cause_d = 4'd11;
    end else if (|exceptF) begin
      epc_d  = pcF;
      tval_d = pcF;
      if      (exceptF[3]) cause_d = 4'd3;
      else if (exceptF[2]) cause_d = 4'd12;
      else if (exceptF[1]) cause_d = 4'd1;
      else                 cause_d = 4'd0;
    end
  end

  // Outputs are registered alongside the state so nothing combinational reaches a port.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      kind_mret     <= 1'b0;
      cause_q       <= 4'd0;
      epc_q         <= '0;
      tval_q        <= '0;
      stall         <= 1'b0;
      flush         <= 1'b0;
      redirectValid <= 1'b0;
      inTrap        <= 1'b0;
      pcRedirect    <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_exc || mretD) begin
            state     <= FLUSH;
            kind_mret <= !any_exc;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            tval_q    <= tval_d;
            stall     <= 1'b1;
            flush     <= 1'b1;
            inTrap    <= 1'b1;
          end
        end
        FLUSH: begin
          if (kind_mret) begin
            state         <= REDIRECT;
            flush         <= 1'b0;
            redirectValid <= 1'b1;
            pcRedirect    <= mepc;
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          mepc          <= {epc_q[N-1:2], 2'b00};
          mcause        <= {{(N-4){1'b0}}, cause_q};
          mtval         <= tval_q;
          state         <= REDIRECT;
          flush         <= 1'b0;
          redirectValid <= 1'b1;
          pcRedirect    <= {mtvec[N-1:2], 2'b00};
        end
        REDIRECT: begin
          if (fetchReady) begin
            state         <= IDLE;
            stall         <= 1'b0;
            inTrap        <= 1'b0;
            redirectValid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traps/mrets
// compared against a table-driven priority model and a CSR shadow.
module tb_trap_ctrl;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   exceptF;
  logic [N-1:0] pcF;
  logic [2:0]   exceptD;
  logic         mretD;
  logic [N-1:0] pcD;
  logic [5:0]   exceptM;
  logic [N-1:0] pcM;
  logic [N-1:0] addrM;
  logic [N-1:0] mtvec;
  logic         fetchReady;
  logic         stall;
  logic         flush;
  logic         redirectValid;
  logic [N-1:0] pcRedirect;
  logic [N-1:0] mepc;
  logic [N-1:0] mtval;
  logic [N-1:0] mcause;
  logic         inTrap;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_mepc, m_mcause, m_mtval;

  typedef struct packed {
    logic        trap;
    logic [3:0]  cause;
    logic [63:0] epc;
    logic [63:0] tval;
  } exp_t;

  trap_ctrl #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .exceptF(exceptF), .pcF(pcF),
    .exceptD(exceptD), .mretD(mretD), .pcD(pcD),
    .exceptM(exceptM), .pcM(pcM), .addrM(addrM),
    .mtvec(mtvec), .fetchReady(fetchReady),
    .stall(stall), .flush(flush),
    .redirectValid(redirectValid), .pcRedirect(pcRedirect),
    .mepc(mepc), .mtval(mtval), .mcause(mcause), .inTrap(inTrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Priority tables straight from the cause lists: position = priority, entry = vector bit.
  function automatic exp_t model(input logic [3:0] f, input logic [2:0] d, input logic [5:0] m,
                                 input logic [63:0] pf, input logic [63:0] pd,
                                 input logic [63:0] pm, input logic [63:0] am);
    int m_bit[6]   = '{0, 2, 4, 1, 3, 5};
    int m_cause[6] = '{4, 5, 13, 6, 7, 15};
    int d_bit[3]   = '{0, 1, 2};
    int d_cause[3] = '{2, 3, 11};
    int f_bit[4]   = '{3, 2, 1, 0};
    int f_cause[4] = '{3, 12, 1, 0};
    exp_t r;
    bit found;
    r = '0;
    found = 0;
    if (m != 0) begin
      r.trap = 1; r.epc = pm; r.tval = am;
      for (int i = 0; i < 6; i++)
        if (!found && m[m_bit[i]]) begin r.cause = 4'(m_cause[i]); found = 1; end
    end else if (d != 0) begin
      r.trap = 1; r.epc = pd; r.tval = 0;
      for (int i = 0; i < 3; i++)
        if (!found && d[d_bit[i]]) begin r.cause = 4'(d_cause[i]); found = 1; end
    end else if (f != 0) begin
      r.trap = 1; r.epc = pf; r.tval = pf;
      for (int i = 0; i < 4; i++)
        if (!found && f[f_bit[i]]) begin r.cause = 4'(f_cause[i]); found = 1; end
    end
    return r;
  endfunction

  task automatic clear_events();
    exceptF = '0; exceptD = '0; exceptM = '0; mretD = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] f, input logic [2:0] d, input logic [5:0] m,
                         input logic mr, input logic [63:0] pf, input logic [63:0] pd,
                         input logic [63:0] pm, input logic [63:0] am,
                         input logic [63:0] tv, input int hold);
    exp_t e;
    int lat;
    logic [63:0] exp_pc;
    e = model(f, d, m, pf, pd, pm, am);
    @(negedge clk);
    exceptF = f; exceptD = d; exceptM = m; mretD = mr;
    pcF = pf; pcD = pd; pcM = pm; addrM = am; mtvec = tv; fetchReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear_events();
    check("flush_state_stall", stall, 1);
    check("flush_state_flush", flush, 1);
    lat = 1;
    while (!redirectValid && lat < 8) begin
      check("csr_before_commit", mepc, m_mepc);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("redirect_latency", lat, e.trap ? 3 : 2);
    if (e.trap) begin
      m_mepc   = {e.epc[63:2], 2'b00};
      m_mcause = {60'd0, e.cause};
      m_mtval  = e.tval;
      exp_pc   = tv & ~64'h3;
    end else begin
      exp_pc = m_mepc;
    end
    check("mepc", mepc, m_mepc);
    check("mcause", mcause, m_mcause);
    check("mtval", mtval, m_mtval);
    check("pc_redirect", pcRedirect, exp_pc);
    check("redirect_flush", flush, 0);
    check("redirect_stall", stall, 1);
    check("redirect_intrap", inTrap, 1);
    for (int i = 0; i < hold; i++) begin
      exceptF = 4'($urandom); exceptD = 3'($urandom); exceptM = 6'($urandom);
      mretD = 1'($urandom); pcM = {$urandom, $urandom}; addrM = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", redirectValid, 1);
      check("hold_stall", stall, 1);
      check("hold_pc", pcRedirect, exp_pc);
      check("hold_mcause", mcause, m_mcause);
    end
    clear_events();
    fetchReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetchReady = 1'b0;
    check("done_valid", redirectValid, 0);
    check("done_stall", stall, 0);
    check("done_intrap", inTrap, 0);
    check("done_flush", flush, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_valid"}, redirectValid, 0);
    check({tag, "_intrap"}, inTrap, 0);
    check({tag, "_pc"}, pcRedirect, 0);
    check({tag, "_mepc"}, mepc, 0);
    check({tag, "_mcause"}, mcause, 0);
    check({tag, "_mtval"}, mtval, 0);
  endtask

  initial begin
    logic [3:0] rf;
    logic [2:0] rd;
    logic [5:0] rm;
    logic rmr;
    reset_n = 1'b0;
    clear_events();
    pcF = '0; pcD = '0; pcM = '0; addrM = '0; mtvec = '0; fetchReady = 1'b0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_quiet", inTrap, 0);

    // Fetch misalign.
    run_seq(4'b0001, 3'b000, 6'b000000, 0, 64'h1002, 64'h0, 64'h0, 64'h0, 64'h8000_0000, 0);
    // M beats D and F.
    run_seq(4'b0001, 3'b001, 6'b000100, 0, 64'h3000, 64'h3004, 64'h4000, 64'hDEAD0, 64'h8000_0100, 1);
    // Breakpoint has top fetch priority.
    run_seq(4'b1110, 3'b000, 6'b000000, 0, 64'h5008, 64'h0, 64'h0, 64'h0, 64'h8000_0003, 0);
    // Illegal has top decode priority; tval 0.
    run_seq(4'b0000, 3'b111, 6'b000000, 0, 64'h0, 64'h6004, 64'h0, 64'hFFFF, 64'h8000_0000, 0);
    // Set mepc to 0x2000, then mret back to it.
    run_seq(4'b0000, 3'b001, 6'b000000, 0, 64'h0, 64'h2000, 64'h0, 64'h0, 64'h8000_0000, 0);
    run_seq(4'b0000, 3'b000, 6'b000000, 1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h9000_0000, 0);
    // Exception overrides a simultaneous mret.
    run_seq(4'b0000, 3'b100, 6'b000000, 1, 64'h0, 64'h7000, 64'h0, 64'h0, 64'h8000_0000, 0);
    // Long fetch back-pressure with noise on the exception inputs.
    run_seq(4'b0100, 3'b000, 6'b000000, 0, 64'hA00C, 64'h0, 64'h0, 64'h0, 64'h8000_0040, 5);

    // Reset during COMMIT.
    @(negedge clk);
    exceptM = 6'b100000; pcM = 64'hB000; addrM = 64'h1234;
    @(posedge clk);
    @(negedge clk);
    clear_events();
    @(posedge clk);
    @(negedge clk);
    check("commit_flush", flush, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    @(negedge clk);
    reset_n = 1'b1;
    run_seq(4'b0000, 3'b000, 6'b010000, 0, 64'h0, 64'h0, 64'hC006, 64'hCAFE, 64'h8000_0000, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      rf  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      rd  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      rm  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      rmr = 1'($urandom);
      if (rf == 0 && rd == 0 && rm == 0) rmr = 1'b1;
      run_seq(rf, rd, rm, rmr, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
